// File: rtl/inert_fusion_pkg.sv
// inert_pkg: shared definitions for the inertial fusion block.
//   fuse_state_t          - UNCAL / CAL / RUN state encoding
//   ACC_SCALE, ACC_SHIFT  - accelerometer-to-angle scale (x327 >>> 12)
//   DEF_INT_SHIFT         - default integrator-to-angle right shift
//   DEF_CAL_LOG2          - default log2 of the calibration window length
//   DEF_FUSION_STEP       - default per-sample accelerometer correction
// The sensor interface instantiation uses the same DEF_* values.
package inert_pkg;

  typedef enum logic [1:0] {
    UNCAL = 2'd0,
    CAL   = 2'd1,
    RUN   = 2'd2
  } fuse_state_t;

  localparam int ACC_SCALE       = 327;
  localparam int ACC_SHIFT       = 12;
  localparam int DEF_INT_SHIFT   = 11;
  localparam int DEF_CAL_LOG2    = 11;
  localparam int DEF_FUSION_STEP = 512;

endpackage

// File: rtl/inert_fusion_axis.sv
// inert_axis: one axis of gyro bias removal and angle integration.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   clr_i        - clear bias accumulator and integrator
//   acc_en_i     - add sign-extended rate to the bias accumulator
//   latch_i      - latch offset = (accumulator incl. this sample) >>> CAL_LOG2
//   int_en_i     - integrate: int <= int - sext(rt - off) + corr
//   rt_i         - signed angular rate
//   corr_i       - signed integrator correction (zero when fusion is off)
//   angle_o      - signed angle, integrator >>> INT_SHIFT, low 16 bits
module inert_axis
  import inert_pkg::*;
#(
  parameter int INT_SHIFT = DEF_INT_SHIFT,
  parameter int CAL_LOG2  = DEF_CAL_LOG2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr_i,
  input  logic                           acc_en_i,
  input  logic                           latch_i,
  input  logic                           int_en_i,
  input  logic signed [15:0]             rt_i,
  input  logic signed [16+INT_SHIFT:0]   corr_i,
  output logic signed [15:0]             angle_o
);

  localparam int ACC_W = 16 + CAL_LOG2;
  localparam int INT_W = 16 + INT_SHIFT + 1;

  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum_s;
  logic        [15:0]      off_q, off_d, comp_s;
  logic signed [INT_W-1:0] int_q, int_d, int_upd_s;

  // The final calibration sample is folded in before the offset is taken,
  // so the latch uses the post-accumulate sum rather than acc_q.
  assign acc_sum_s = acc_q + {{(ACC_W-16){rt_i[15]}}, rt_i};
  assign comp_s    = rt_i - off_q;
  assign int_upd_s = int_q - {{(INT_W-16){comp_s[15]}}, comp_s} + corr_i;

  // Next-state for accumulator, offset and integrator.
  always_comb begin
    acc_d = acc_q;
    off_d = off_q;
    int_d = int_q;
    if (clr_i) begin
      acc_d = '0;
      int_d = '0;
    end else begin
      if (acc_en_i) begin
        acc_d = acc_sum_s;
      end else begin
        acc_d = acc_q;
      end
      if (latch_i) begin
        off_d = acc_sum_s[CAL_LOG2 +: 16];
      end else begin
        off_d = off_q;
      end
      if (int_en_i) begin
        int_d = int_upd_s;
      end else begin
        int_d = int_q;
      end
    end
  end

  // Axis state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      off_q <= '0;
      int_q <= '0;
    end else begin
      acc_q <= acc_d;
      off_q <= off_d;
      int_q <= int_d;
    end
  end

  assign angle_o = int_q[INT_SHIFT +: 16];

endmodule

// File: rtl/inert_fusion.sv
// inert_fusion: gyro bias calibration and angle integration for pitch,
// roll and yaw, with optional accelerometer pull on pitch/roll.
// Optional feature macro: ACCEL_FUSION_EN (default build: pure integration,
// ax/ay unused, no multipliers).
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   strt_cal                    - pulse: (re)start calibration
//   vld                         - pulse: sample inputs valid this cycle
//   ptch_rt, roll_rt, yaw_rt    - signed angular rates
//   ax, ay                      - signed accelerations
//   cal_done                    - registered one-cycle end-of-calibration pulse
//   ptch, roll, yaw             - signed angles from registered integrators
module inert_fusion
  import inert_pkg::*;
#(
  parameter int INT_SHIFT   = DEF_INT_SHIFT,
  parameter int CAL_LOG2    = DEF_CAL_LOG2,
  parameter int FUSION_STEP = DEF_FUSION_STEP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               strt_cal,
  input  logic               vld,
  input  logic signed [15:0] ptch_rt,
  input  logic signed [15:0] roll_rt,
  input  logic signed [15:0] yaw_rt,
  input  logic signed [15:0] ax,
  input  logic signed [15:0] ay,
  output logic               cal_done,
  output logic signed [15:0] ptch,
  output logic signed [15:0] roll,
  output logic signed [15:0] yaw
);

  localparam int INT_W = 16 + INT_SHIFT + 1;
  localparam logic [CAL_LOG2:0] CNT_LAST = {1'b0, {CAL_LOG2{1'b1}}};
  localparam logic [CAL_LOG2:0] CNT_ONE  = {{CAL_LOG2{1'b0}}, 1'b1};

  fuse_state_t         state_q, state_d;
  logic [CAL_LOG2:0]   cnt_q, cnt_d;
  logic                cal_done_q, cal_done_d;
  logic                clr_s, acc_en_s, latch_s, int_en_s;
  logic signed [INT_W-1:0] ptch_corr_s, roll_corr_s, yaw_corr_s;

  // FSM next state and per-axis enables; strt_cal overrides everything.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cal_done_d = 1'b0;
    clr_s      = 1'b0;
    acc_en_s   = 1'b0;
    latch_s    = 1'b0;
    int_en_s   = 1'b0;
    if (strt_cal) begin
      state_d = CAL;
      cnt_d   = '0;
      clr_s   = 1'b1;
    end else begin
      case (state_q)
        UNCAL: begin
          state_d = UNCAL;
        end
        CAL: begin
          if (vld) begin
            acc_en_s = 1'b1;
            cnt_d    = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
              latch_s    = 1'b1;
              cal_done_d = 1'b1;
              state_d    = RUN;
            end else begin
              state_d = CAL;
            end
          end else begin
            state_d = CAL;
          end
        end
        RUN: begin
          if (vld) begin
            int_en_s = 1'b1;
          end else begin
            int_en_s = 1'b0;
          end
        end
        default: begin
          state_d = UNCAL;
        end
      endcase
    end
  end

  // FSM, sample counter and cal_done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UNCAL;
      cnt_q      <= '0;
      cal_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cal_done_q <= cal_done_d;
    end
  end

  assign cal_done = cal_done_q;

`ifdef ACCEL_FUSION_EN
  logic signed [31:0] ptch_prod_s, roll_prod_s;
  logic signed [15:0] ptch_acc_s, roll_acc_s;

  // Pitch follows ay and roll follows ax; slicing at ACC_SHIFT is the
  // arithmetic shift truncated to 16 bits.
  assign ptch_prod_s = 32'(ay) * 32'(ACC_SCALE);
  assign roll_prod_s = 32'(ax) * 32'(ACC_SCALE);
  assign ptch_acc_s  = ptch_prod_s[ACC_SHIFT +: 16];
  assign roll_acc_s  = roll_prod_s[ACC_SHIFT +: 16];

  // Bang-bang correction toward the accelerometer angle.
  always_comb begin
    ptch_corr_s = '0;
    roll_corr_s = '0;
    if (ptch_acc_s > ptch) begin
      ptch_corr_s = INT_W'(FUSION_STEP);
    end else if (ptch_acc_s < ptch) begin
      ptch_corr_s = -INT_W'(FUSION_STEP);
    end else begin
      ptch_corr_s = '0;
    end
    if (roll_acc_s > roll) begin
      roll_corr_s = INT_W'(FUSION_STEP);
    end else if (roll_acc_s < roll) begin
      roll_corr_s = -INT_W'(FUSION_STEP);
    end else begin
      roll_corr_s = '0;
    end
  end
`else
  logic unused_accel_s;
  assign unused_accel_s = ^{ax, ay};
  assign ptch_corr_s    = '0;
  assign roll_corr_s    = '0;
`endif
  assign yaw_corr_s = '0;

  inert_axis #(.INT_SHIFT(INT_SHIFT), .CAL_LOG2(CAL_LOG2)) u_ptch (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_s), .acc_en_i(acc_en_s),
    .latch_i(latch_s), .int_en_i(int_en_s), .rt_i(ptch_rt),
    .corr_i(ptch_corr_s), .angle_o(ptch)
  );

  inert_axis #(.INT_SHIFT(INT_SHIFT), .CAL_LOG2(CAL_LOG2)) u_roll (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_s), .acc_en_i(acc_en_s),
    .latch_i(latch_s), .int_en_i(int_en_s), .rt_i(roll_rt),
    .corr_i(roll_corr_s), .angle_o(roll)
  );

  inert_axis #(.INT_SHIFT(INT_SHIFT), .CAL_LOG2(CAL_LOG2)) u_yaw (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_s), .acc_en_i(acc_en_s),
    .latch_i(latch_s), .int_en_i(int_en_s), .rt_i(yaw_rt),
    .corr_i(yaw_corr_s), .angle_o(yaw)
  );

endmodule

// File: tb/tb_inert_fusion.sv
// Self-checking bench for inert_fusion (default build, INT_SHIFT = CAL_LOG2 = 11).
// A behavioural model with plain integer arithmetic predicts every output
// after every cycle; directed steps cover reset, calibration, restart,
// wrap-around and back-to-back samples, followed by a randomized phase.
module tb_inert_fusion;

  localparam int  IS   = 11;
  localparam int  CL   = 11;
  localparam int  NCAL = 1 << CL;
  localparam int  M_UNCAL = 0;
  localparam int  M_CAL   = 1;
  localparam int  M_RUN   = 2;

  logic               clk;
  logic               rst_n;
  logic               strt_cal;
  logic               vld;
  logic signed [15:0] ptch_rt, roll_rt, yaw_rt, ax, ay;
  logic               cal_done;
  logic signed [15:0] ptch, roll, yaw;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int     m_state;
  int     m_cnt;
  longint m_acc [3];
  longint m_off [3];
  longint m_int [3];
  bit     m_done;

  inert_fusion dut (
    .clk(clk), .rst_n(rst_n), .strt_cal(strt_cal), .vld(vld),
    .ptch_rt(ptch_rt), .roll_rt(roll_rt), .yaw_rt(yaw_rt),
    .ax(ax), .ay(ay), .cal_done(cal_done),
    .ptch(ptch), .roll(roll), .yaw(yaw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint wrapn(input longint x, input int n);
    longint m;
    longint w;
    m = longint'(1) <<< n;
    w = x & (m - 1);
    if (w >= m / 2) w = w - m;
    return w;
  endfunction

  function automatic logic [15:0] exp_angle(input int ax_i);
    longint t;
    t = m_int[ax_i] >>> IS;
    return t[15:0];
  endfunction

  task automatic model_reset();
    m_state = M_UNCAL;
    m_cnt   = 0;
    m_done  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_off[i] = 0; m_int[i] = 0;
    end
  endtask

  task automatic model_step(input logic s, input logic v,
                            input logic [15:0] p, input logic [15:0] r,
                            input logic [15:0] y);
    longint rt [3];
    rt[0] = longint'($signed(p));
    rt[1] = longint'($signed(r));
    rt[2] = longint'($signed(y));
    m_done = 1'b0;
    if (s) begin
      m_state = M_CAL;
      m_cnt   = 0;
      for (int i = 0; i < 3; i++) begin
        m_acc[i] = 0; m_int[i] = 0;
      end
    end else if (m_state == M_CAL && v) begin
      m_cnt++;
      for (int i = 0; i < 3; i++) m_acc[i] += rt[i];
      if (m_cnt == NCAL) begin
        for (int i = 0; i < 3; i++) m_off[i] = wrapn(m_acc[i] >>> CL, 16);
        m_state = M_RUN;
        m_done  = 1'b1;
      end
    end else if (m_state == M_RUN && v) begin
      for (int i = 0; i < 3; i++)
        m_int[i] = wrapn(m_int[i] - wrapn(rt[i] - m_off[i], 16), 16 + IS + 1);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cal_done", {15'd0, cal_done}, {15'd0, m_done});
    chk("ptch", ptch, exp_angle(0));
    chk("roll", roll, exp_angle(1));
    chk("yaw",  yaw,  exp_angle(2));
  endtask

  task automatic tick(input logic s, input logic v, input logic [15:0] p,
                      input logic [15:0] r, input logic [15:0] y);
    strt_cal = s; vld = v;
    ptch_rt = p; roll_rt = r; yaw_rt = y;
    ax = 16'($urandom); ay = 16'($urandom);
    @(posedge clk);
    #1;
    model_step(s, v, p, r, y);
    strt_cal = 1'b0; vld = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    strt_cal = 1'b0; vld = 1'b0;
    ptch_rt = 16'sd0; roll_rt = 16'sd0; yaw_rt = 16'sd0; ax = 16'sd0; ay = 16'sd0;
    rst_n = 1'b1;
    #2;
    do_reset();
    check_all();

    // UNCAL ignores samples
    for (int i = 0; i < 5; i++)
      tick(1'b0, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
    tick(1'b0, 1'b1, 16'd100, 16'd0, 16'd0);
    chk("uncal_ptch", ptch, 16'h0000);

    // Partial calibration, restart (coincident vld not counted), full window
    tick(1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
    for (int i = 0; i < 1000; i++)
      tick(1'b0, 1'b1, 16'($urandom_range(0, 400)), 16'($urandom), 16'd7);
    tick(1'b1, 1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < NCAL - 1; i++)
      tick(1'b0, 1'b1, 16'h0040, 16'hFFF0, 16'h0000);
    chk("cal_done_early", {15'd0, cal_done}, 16'd0);
    tick(1'b0, 1'b1, 16'h0040, 16'hFFF0, 16'h0000);
    chk("cal_done_pulse", {15'd0, cal_done}, 16'd1);
    // Offsets 64/-16/0 cancel these rates exactly
    for (int i = 0; i < 50; i++)
      tick(1'b0, 1'b1, 16'h0040, 16'hFFF0, 16'h0000);
    chk("cal_done_once", {15'd0, cal_done}, 16'd0);
    chk("off_ptch", ptch, 16'h0000);
    chk("off_roll", roll, 16'h0000);

    // Recalibrate with zero rates and gapped vld, then pure integration
    tick(1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
    for (int i = 0; i < NCAL; i++) begin
      tick(1'b0, 1'b1, 16'd0, 16'd0, 16'd0);
      if (i % 3 == 0) tick(1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
    end
    for (int i = 0; i < NCAL; i++)
      tick(1'b0, 1'b1, 16'hFFFF, 16'd0, 16'd0);
    chk("ptch_one", ptch, 16'h0001);
    for (int i = 0; i < NCAL; i++)
      tick(1'b0, 1'b1, 16'd0, 16'd0, 16'h7FFF);
    chk("yaw_2048", yaw, 16'h8001);
    for (int i = 0; i < 3000; i++)
      tick(1'b0, 1'b1, 16'd0, 16'd0, 16'h7FFF);
    chk("yaw_wrap", yaw, exp_angle(2));

    // Back-to-back samples, +1 per cycle
    for (int i = 0; i < 100; i++)
      tick(1'b0, 1'b1, 16'hF800, 16'd0, 16'd0);
    chk("ptch_b2b", ptch, 16'd101);

    // Randomized run with occasional restarts
    for (int i = 0; i < 3000; i++)
      tick(($urandom_range(0, 999) == 0), ($urandom_range(0, 3) != 0),
           16'($urandom), 16'($urandom), 16'($urandom));

    // Reset mid-run, then a sample in UNCAL
    tick(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    do_reset();
    chk("rst_ptch", ptch, 16'h0000);
    tick(1'b0, 1'b1, 16'd100, 16'd0, 16'd0);
    chk("rst_vld_ptch", ptch, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inert_fusion.md
# inert_fusion

Consumes the raw inertial samples produced by the sensor-read interface: pitch/roll/yaw rates, ax, ay, and a one-cycle `vld` per sample set. It removes the gyro bias, measured over a calibration window, and integrates the bias-corrected rates into signed 16-bit pitch, roll and yaw angles. Pitch and roll can optionally be pulled toward accelerometer-derived angles. It feeds the flight controller directly.

## Interface
- `INT_SHIFT`, default 11: right shift from integrator to angle output.
- `CAL_LOG2`, default 11: calibration window is 2^CAL_LOG2 samples.
- `FUSION_STEP`, default 512: per-sample correction magnitude applied to the pitch/roll integrators.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low; clock is clk.
- `strt_cal`  in  1  one-cycle pulse that starts or restarts calibration.
- `vld`  in  1  one-cycle pulse; all sample inputs are valid this cycle.
- `ptch_rt`, `roll_rt`, `yaw_rt`  in  16 each  signed angular rates.
- `ax`, `ay`  in  16 each  signed accelerations.
- `cal_done`  out  1  one-cycle pulse marking the end of calibration.
- `ptch`, `roll`, `yaw`  out  16 each  signed angles.

## Operation
- State machine: UNCAL (the reset state), CAL, RUN.
- UNCAL:
  - `vld` is ignored.
  - Integrators and offsets are held at 0.
- Entering CAL:
  - `strt_cal` in any state moves to CAL.
  - On entry, clear the sample counter (CAL_LOG2+1 bits), the three bias accumulators (16+CAL_LOG2 bits, signed) and the three angle integrators.
  - `strt_cal` in RUN or mid-CAL discards all calibration progress.
- CAL:
  - On each `vld`, add each sign-extended rate to its accumulator and increment the counter.
  - On the `vld` that makes the count equal 2^CAL_LOG2, the accumulate still happens. The block then latches offset = accumulator >>> CAL_LOG2 (arithmetic, low 16 bits) for each axis and goes to RUN.
- RUN, on each `vld`:
  - Compensated rate: comp = rt − off, 16-bit wrap.
  - Integrator update: int ← int − sext(comp) + corr.
  - `corr` is 0 unless ACCEL_FUSION_EN is defined; see Configuration.
  - Integrators are signed, 16+INT_SHIFT+1 bits, two's-complement wrap with no saturation.
- Outputs: angle = int >>> INT_SHIFT, low 16 bits, taken from registered integrators.
- Simultaneous events:
  - `strt_cal` and `vld` in the same cycle: `strt_cal` wins and the sample is not counted.
  - `vld` while in UNCAL has no effect.

## Timing
- Reset values: `cal_done` = 0; `ptch`, `roll`, `yaw` = 16'h0000; state = UNCAL; all counters, accumulators, offsets and integrators = 0.
- `vld` at cycle N updates the integrators at edge N+1. Outputs reflect the new value in cycle N+1, one cycle of latency.
- `cal_done` is registered and high for exactly one cycle, the cycle after the final calibration `vld`. It coincides with entry to RUN.
- A `vld` arriving in the same cycle `cal_done` is high is integrated.
- Inputs are sampled only when `vld` = 1.
- `vld` pulses may be back-to-back, one per cycle, with no loss.

## Configuration
- Macro: `ACCEL_FUSION_EN`.
- Defined:
  - Accelerometer angles: ptch_acc = (sext(ay) × 327) >>> 12 and roll_acc = (sext(ax) × 327) >>> 12. Products are 32-bit signed; results are truncated to 16 bits.
  - In RUN on `vld`, pitch correction = +FUSION_STEP if ptch_acc > current `ptch` (signed compare), −FUSION_STEP if less, 0 if equal. Roll uses the same rule with roll_acc.
  - Yaw is never fused.
- Not defined:
  - corr = 0 for all axes, giving pure integration.
  - `ax`/`ay` are unused; the multiplier logic must not be present.

## Structure
- Shared package `inert_pkg` holds:
  - the state enum `fuse_state_t` (UNCAL/CAL/RUN);
  - the accelerometer scale constant 327 and its shift 12;
  - the default INT_SHIFT and CAL_LOG2 values. The same defaults are used by the sensor interface instantiation.
- Sub-module `inert_axis`, instantiated three times:
  - contents: one bias accumulator, offset register, and integrator;
  - inputs: clear, accumulate, latch-offset, and integrate enables plus a signed correction input.
  - The top level holds the FSM, the sample counter and the optional fusion logic.

## Test plan
1. Reset mid-RUN → all outputs 0 next cycle, state UNCAL; a following `vld` with `ptch_rt` = 100 leaves `ptch` = 0.
2. Calibration with CAL_LOG2 = 11: `strt_cal`, then 2048 `vld` with `ptch_rt` = 16'h0040, `roll_rt` = 16'hFFF0, `yaw_rt` = 0 → offsets 64/−16/0, and `cal_done` high exactly one cycle, the cycle after the 2048th `vld`.
3. RUN, fusion off, offset 0: 2048 `vld` with `ptch_rt` = −1 → `ptch` = 1. Then 2048 × `yaw_rt` = 16'h7FFF → `yaw` wraps per the 28-bit integrator with no saturation.
4. `strt_cal` after 1000 calibration samples → count restarts; 2048 further samples are required before `cal_done`. `strt_cal` coincident with `vld` → that sample is not counted.
5. ACCEL_FUSION_EN, zero rates, `ay` = 16'h1000 → ptch_acc = 327; the pitch integrator grows by 512 per `vld` until `ptch` reaches 327, then dithers ±512 at the integrator.
6. Back-to-back `vld` on every cycle for 100 cycles in RUN with `ptch_rt` = −2048, INT_SHIFT = 11 → `ptch` increments by 1 every cycle.
